// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_gen_pkg
//  Description : Shared types and constants for the multi-channel pulse
//                generator (channel state encoding, mode encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

    // Channel FSM state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    // Mode encoding as written through the configuration port
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage : pulse_gen_pkg
`default_nettype wire

// File: rtl/pulse_gen_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_gen_chan
//  Description : One pulse generator channel: active/shadow configuration,
//                period counter and IDLE/RUN state machine with registered
//                pulse, busy and done outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_gen_chan
    import pulse_gen_pkg::*;
#(
    parameter int DIV_WIDTH    = 16,
    parameter int RESET_PERIOD = 10,
    parameter int RESET_HIGH   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [DIV_WIDTH-1:0] cfg_period,
    input  logic [DIV_WIDTH-1:0] cfg_high,
    input  logic                 cfg_mode,
    input  logic                 start,
    input  logic                 stop,
    output logic                 pulse,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DIV_WIDTH-1:0] C_RST_PERIOD = DIV_WIDTH'(RESET_PERIOD);
    localparam logic [DIV_WIDTH-1:0] C_RST_HIGH   = DIV_WIDTH'(RESET_HIGH);
    localparam logic [DIV_WIDTH-1:0] C_ONE        = DIV_WIDTH'(1);

    chan_state_t          r_state, w_state;
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt;
    logic [DIV_WIDTH-1:0] r_act_p, w_act_p;
    logic [DIV_WIDTH-1:0] r_act_h, w_act_h;
    logic                 r_act_m, w_act_m;
    logic [DIV_WIDTH-1:0] r_sh_p, w_sh_p;
    logic [DIV_WIDTH-1:0] r_sh_h, w_sh_h;
    logic                 r_sh_m, w_sh_m;
    logic                 r_pulse, w_pulse;
    logic                 r_busy, w_busy;
    logic                 r_done, w_done;

    // Config source for a (re)load: a write on the same edge takes precedence
    logic [DIV_WIDTH-1:0] w_src_p, w_src_h;
    logic                 w_src_m;
    // Last counter value of the current period; P == 0 behaves as P == 1
    logic [DIV_WIDTH-1:0] w_last;

    // State, counter, configuration and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_act_p <= C_RST_PERIOD;
            r_act_h <= C_RST_HIGH;
            r_act_m <= MODE_PERIODIC;
            r_sh_p  <= C_RST_PERIOD;
            r_sh_h  <= C_RST_HIGH;
            r_sh_m  <= MODE_PERIODIC;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_act_p <= w_act_p;
            r_act_h <= w_act_h;
            r_act_m <= w_act_m;
            r_sh_p  <= w_sh_p;
            r_sh_h  <= w_sh_h;
            r_sh_m  <= w_sh_m;
            r_pulse <= w_pulse;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Next-state logic; outputs are derived from next-state values so they
    // become visible on the same edge that starts, stops or wraps the channel
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_act_p = r_act_p;
        w_act_h = r_act_h;
        w_act_m = r_act_m;
        w_sh_p  = r_sh_p;
        w_sh_h  = r_sh_h;
        w_sh_m  = r_sh_m;
        w_done  = 1'b0;

        w_src_p = cfg_we ? cfg_period : r_sh_p;
        w_src_h = cfg_we ? cfg_high   : r_sh_h;
        w_src_m = cfg_we ? cfg_mode   : r_sh_m;
        w_last  = (r_act_p == '0) ? '0 : (r_act_p - C_ONE);

        // Writes always land in the shadow; an idle channel also takes them
        // into the active set immediately
        if (cfg_we) begin
            w_sh_p = cfg_period;
            w_sh_h = cfg_high;
            w_sh_m = cfg_mode;
            if (r_state == ST_IDLE) begin
                w_act_p = cfg_period;
                w_act_h = cfg_high;
                w_act_m = cfg_mode;
            end
        end

        if (stop) begin
            // Stop overrides start and any coinciding period boundary
            w_state = ST_IDLE;
            w_cnt   = '0;
        end else if (start) begin
            // Start from idle or retrigger while running
            w_state = ST_RUN;
            w_cnt   = '0;
            w_act_p = w_src_p;
            w_act_h = w_src_h;
            w_act_m = w_src_m;
        end else if (r_state == ST_RUN) begin
            if (r_cnt == w_last) begin
                w_cnt = '0;
                if (r_act_m == MODE_ONESHOT) begin
                    w_state = ST_IDLE;
                    w_done  = 1'b1;
                end else begin
                    // New configuration only takes effect at boundaries
                    w_act_p = w_src_p;
                    w_act_h = w_src_h;
                    w_act_m = w_src_m;
                end
            end else begin
                w_cnt = r_cnt + C_ONE;
            end
        end

        w_busy  = (w_state == ST_RUN);
        w_pulse = (w_state == ST_RUN) && (w_cnt < w_act_h);
    end

    assign pulse = r_pulse;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : pulse_gen_chan
`default_nettype wire

// File: rtl/pulse_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_gen_multi
//  Description : Multi-channel programmable pulse generator. Decodes the
//                configuration port into per-channel write enables and
//                instantiates CHANNELS independent channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter  int CHANNELS     = 4,
    parameter  int DIV_WIDTH    = 16,
    parameter  int RESET_PERIOD = 10,
    parameter  int RESET_HIGH   = 1,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 CLK_IN,
    input  logic                 RST_N_IN,
    input  logic                 CFG_WE_IN,
    input  logic [CH_W-1:0]      CFG_CH_IN,
    input  logic [DIV_WIDTH-1:0] CFG_PERIOD_IN,
    input  logic [DIV_WIDTH-1:0] CFG_HIGH_IN,
    input  logic                 CFG_MODE_IN,
    input  logic [CHANNELS-1:0]  START_IN,
    input  logic [CHANNELS-1:0]  STOP_IN,
    output logic [CHANNELS-1:0]  PULSE_OUT,
    output logic [CHANNELS-1:0]  BUSY_OUT,
    output logic [CHANNELS-1:0]  DONE_OUT
);

    // Channel indices at or above CHANNELS match no instance and are dropped
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            logic w_we;

            assign w_we = CFG_WE_IN && (CFG_CH_IN == CH_W'(i));

            pulse_gen_chan #(
                .DIV_WIDTH    (DIV_WIDTH),
                .RESET_PERIOD (RESET_PERIOD),
                .RESET_HIGH   (RESET_HIGH)
            ) u_chan (
                .clk        (CLK_IN),
                .rst_n      (RST_N_IN),
                .cfg_we     (w_we),
                .cfg_period (CFG_PERIOD_IN),
                .cfg_high   (CFG_HIGH_IN),
                .cfg_mode   (CFG_MODE_IN),
                .start      (START_IN[i]),
                .stop       (STOP_IN[i]),
                .pulse      (PULSE_OUT[i]),
                .busy       (BUSY_OUT[i]),
                .done       (DONE_OUT[i])
            );
        end
    endgenerate

endmodule : pulse_gen_multi
`default_nettype wire

// File: tb/tb_pulse_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_gen_multi
//  Description : Directed self-checking bench for pulse_gen_multi. Five
//                channels are used so that an out-of-range channel index
//                can be presented on the 3-bit configuration select.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_gen_multi;

    localparam int NCH = 5;
    localparam int DW  = 16;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [2:0]    cfg_ch;
    logic [DW-1:0] cfg_period;
    logic [DW-1:0] cfg_high;
    logic          cfg_mode;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cap_p, cap_b, cap_d;

    pulse_gen_multi #(
        .CHANNELS     (NCH),
        .DIV_WIDTH    (DW),
        .RESET_PERIOD (10),
        .RESET_HIGH   (1)
    ) dut (
        .CLK_IN        (clk),
        .RST_N_IN      (rst_n),
        .CFG_WE_IN     (cfg_we),
        .CFG_CH_IN     (cfg_ch),
        .CFG_PERIOD_IN (cfg_period),
        .CFG_HIGH_IN   (cfg_high),
        .CFG_MODE_IN   (cfg_mode),
        .START_IN      (start),
        .STOP_IN       (stop),
        .PULSE_OUT     (pulse),
        .BUSY_OUT      (busy),
        .DONE_OUT      (done)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input int p, input int h, input logic m);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = DW'(p);
        cfg_high   = DW'(h);
        cfg_mode   = m;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic start_ch(input logic [NCH-1:0] mask);
        start = mask;
        tick();
        start = '0;
    endtask

    task automatic stop_ch(input logic [NCH-1:0] mask);
        stop = mask;
        tick();
        stop = '0;
    endtask

    // Sample one channel's outputs for n cycles; bit i is cycle i
    task automatic capture(input int ch, input int n);
        cap_p = '0;
        cap_b = '0;
        cap_d = '0;
        for (int i = 0; i < n; i++) begin
            cap_p[i] = pulse[ch];
            cap_b[i] = busy[ch];
            cap_d[i] = done[ch];
            tick();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_mode   = 1'b0;
        start      = '0;
        stop       = '0;

        // Reset state
        tick();
        tick();
        check("rst_pulse", 32'(pulse), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        rst_n = 1'b1;
        tick();

        // Channel 0 with reset config 10/1 periodic
        start_ch(5'b00001);
        capture(0, 20);
        check("ch0_pulse", cap_p, 32'h00401);
        check("ch0_busy",  cap_b, 32'hFFFFF);
        check("ch0_done",  cap_d, 32'h0);
        stop_ch(5'b00001);
        check("ch0_stop_busy",  32'(busy[0]),  32'h0);
        check("ch0_stop_pulse", 32'(pulse[0]), 32'h0);

        // Channel 1: 8/3 periodic, then mid-period rewrite to 4/2
        cfg_write(3'd1, 8, 3, 1'b0);
        start_ch(5'b00010);
        capture(1, 16);
        check("ch1_3of8", cap_p, 32'h0707);
        cfg_write(3'd1, 4, 2, 1'b0);
        capture(1, 15);
        check("ch1_switch", cap_p, 32'h1983);
        check("ch1_busy",   cap_b, 32'h7FFF);
        stop_ch(5'b00010);

        // Channel 2: 5/2 one-shot
        cfg_write(3'd2, 5, 2, 1'b1);
        start_ch(5'b00100);
        capture(2, 8);
        check("ch2_os_pulse", cap_p, 32'h03);
        check("ch2_os_busy",  cap_b, 32'h1F);
        check("ch2_os_done",  cap_d, 32'h20);

        // Channel 4 edge values: P=0 one-shot lasts one cycle
        cfg_write(3'd4, 0, 1, 1'b1);
        start_ch(5'b10000);
        capture(4, 4);
        check("p0_busy",  cap_b, 32'h1);
        check("p0_done",  cap_d, 32'h2);
        check("p0_pulse", cap_p, 32'h1);

        // H=0 never high while running
        cfg_write(3'd4, 4, 0, 1'b0);
        start_ch(5'b10000);
        capture(4, 8);
        check("h0_pulse", cap_p, 32'h00);
        check("h0_busy",  cap_b, 32'hFF);
        stop_ch(5'b10000);

        // H > P is constant high
        cfg_write(3'd4, 4, 7, 1'b0);
        start_ch(5'b10000);
        capture(4, 8);
        check("hgtp_pulse", cap_p, 32'hFF);
        stop_ch(5'b10000);

        // Channel 3: START and STOP on the same edge stays idle
        start = 5'b01000;
        stop  = 5'b01000;
        tick();
        start = '0;
        stop  = '0;
        check("ss_busy",  32'(busy[3]),  32'h0);
        check("ss_pulse", 32'(pulse[3]), 32'h0);

        // STOP during a one-shot gives no DONE
        cfg_write(3'd3, 6, 2, 1'b1);
        start_ch(5'b01000);
        capture(3, 2);
        stop_ch(5'b01000);
        capture(3, 8);
        check("os_stop_busy", cap_b, 32'h0);
        check("os_stop_done", cap_d, 32'h0);

        // Retrigger at counter 3 restarts the one-shot
        start_ch(5'b01000);
        capture(3, 3);
        check("rt_pre_pulse", cap_p, 32'h3);
        start_ch(5'b01000);
        capture(3, 8);
        check("rt_pulse", cap_p, 32'h03);
        check("rt_busy",  cap_b, 32'h3F);
        check("rt_done",  cap_d, 32'h40);

        // Asynchronous reset in the middle of a cycle while all channels run
        start_ch(5'b11111);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pulse", 32'(pulse), 32'h0);
        check("arst_busy",  32'(busy),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Channel 1 config back to 10/1 periodic
        start_ch(5'b00010);
        capture(1, 12);
        check("rst_cfg_pulse", cap_p, 32'h401);
        check("rst_cfg_busy",  cap_b, 32'hFFF);
        stop_ch(5'b00010);

        // Write to channel index 5 (out of range) must not touch any channel
        cfg_write(3'd5, 3, 3, 1'b1);
        start_ch(5'b11111);
        check("oor_cyc0", 32'(pulse), 32'h1F);
        tick();
        check("oor_cyc1_pulse", 32'(pulse), 32'h00);
        check("oor_cyc1_busy",  32'(busy),  32'h1F);
        for (int i = 0; i < 9; i++) tick();
        check("oor_cyc10", 32'(pulse), 32'h1F);
        check("oor_done",  32'(done),  32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pulse_gen_multi
`default_nettype wire
